// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: IEEE 1149.1 target-side TAP for emulation builds.
// All JTAG pins are oversampled in the clk domain. TCK edges are detected
// from the synchronized samples, so no TCK clock tree exists.
// Registers: IR, BYPASS, IDCODE and one USER data register that is
// visible to core logic.
module jtag_tap_responder #(
  parameter int                IR_W     = 5,
  parameter int                DR_W     = 32,
  parameter logic [31:0]       IDCODE   = 32'h0000_0001,
  parameter logic [IR_W-1:0]   INS_IDC  = 'h01,
  parameter logic [IR_W-1:0]   INS_USER = 'h02
) (
  input  logic            clk,
  input  logic            rst_a,
  input  logic            jtag_tck,
  input  logic            jtag_tms,
  input  logic            jtag_tdi,
  input  logic            jtag_trst_n,
  output logic            jtag_tdo,
  output logic            jtag_tdo_oe,
  input  logic [DR_W-1:0] user_dr_in,
  output logic [DR_W-1:0] user_dr_out,
  output logic            user_dr_upd,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_out
);

  typedef enum logic [3:0] {
    S_TLR    = 4'hF, S_RTI    = 4'hC,
    S_SEL_DR = 4'h7, S_CAP_DR = 4'h6, S_SH_DR  = 4'h2, S_EX1_DR = 4'h1,
    S_PAU_DR = 4'h3, S_EX2_DR = 4'h0, S_UPD_DR = 4'h5,
    S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR  = 4'hA, S_EX1_IR = 4'h9,
    S_PAU_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {DR_BYP, DR_IDC, DR_USR} dr_sel_e;

  // Synchronizers. The third tck stage exists only for edge detection.
  logic [2:0] tck_sync_q,  tck_sync_d;
  logic [1:0] tms_sync_q,  tms_sync_d;
  logic [1:0] tdi_sync_q,  tdi_sync_d;
  logic [1:0] trst_sync_q, trst_sync_d;

  // TAP state and scan registers.
  tap_state_e      state_q,   state_d;
  logic [IR_W-1:0] ir_q,      ir_d;
  logic [IR_W-1:0] ir_sh_q,   ir_sh_d;
  logic [31:0]     idc_sh_q,  idc_sh_d;
  logic [DR_W-1:0] usr_sh_q,  usr_sh_d;
  logic            byp_q,     byp_d;
  logic            tdo_q,     tdo_d;
  logic            tdo_oe_q,  tdo_oe_d;
  logic [DR_W-1:0] dr_out_q,  dr_out_d;
  logic            dr_upd_q,  dr_upd_d;

  logic    tck_rise;
  logic    tck_fall;
  logic    tms_s;
  logic    tdi_s;
  logic    trst_s;
  dr_sel_e dr_sel;

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s    = tms_sync_q[1];
  assign tdi_s    = tdi_sync_q[1];
  assign trst_s   = ~trst_sync_q[1];

  // 1149.1 state transition table, advanced once per TCK rise.
  function automatic tap_state_e next_tap(input tap_state_e s, input logic tms);
    case (s)
      S_TLR:    next_tap = tms ? S_TLR    : S_RTI;
      S_RTI:    next_tap = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: next_tap = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: next_tap = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  next_tap = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: next_tap = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: next_tap = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: next_tap = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: next_tap = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: next_tap = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: next_tap = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  next_tap = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: next_tap = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: next_tap = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: next_tap = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: next_tap = tms ? S_SEL_DR : S_RTI;
      default:  next_tap = S_TLR;
    endcase
  endfunction

  // Decode the current instruction into a data register select. Any
  // opcode other than IDCODE or USER, including all-ones, selects BYPASS.
  always_comb begin
    if (ir_q == INS_IDC)       dr_sel = DR_IDC;
    else if (ir_q == INS_USER) dr_sel = DR_USR;
    else                       dr_sel = DR_BYP;
  end

  // Shift the pin samples along their synchronizer chains.
  always_comb begin
    tck_sync_d  = {tck_sync_q[1:0], jtag_tck};
    tms_sync_d  = {tms_sync_q[0],   jtag_tms};
    tdi_sync_d  = {tdi_sync_q[0],   jtag_tdi};
    trst_sync_d = {trst_sync_q[0],  jtag_trst_n};
  end

  // TAP next-state and register actions. TRST wins over any TCK edge in
  // the same cycle.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d  = state_q;
    ir_d     = ir_q;
    ir_sh_d  = ir_sh_q;
    idc_sh_d = idc_sh_q;
    usr_sh_d = usr_sh_q;
    byp_d    = byp_q;
    tdo_d    = tdo_q;
    tdo_oe_d = tdo_oe_q;
    dr_out_d = dr_out_q;
    dr_upd_d = 1'b0;

    if (trst_s) begin
      state_d  = S_TLR;
      ir_d     = INS_IDC;
      ir_sh_d  = '0;
      idc_sh_d = '0;
      usr_sh_d = '0;
      byp_d    = 1'b0;
      tdo_d    = 1'b0;
      tdo_oe_d = 1'b0;
    end else if (tck_rise) begin
      state_d = next_tap(state_q, tms_s);
      case (state_q)
        S_CAP_IR: begin
          ir_sh_d    = '0;
          ir_sh_d[0] = 1'b1;
        end
        S_SH_IR: begin
          ir_sh_d         = ir_sh_q >> 1;
          ir_sh_d[IR_W-1] = tdi_s;
        end
        S_UPD_IR: ir_d = ir_sh_q;
        S_CAP_DR: begin
          case (dr_sel)
            DR_IDC:  idc_sh_d = IDCODE;
            DR_USR:  usr_sh_d = user_dr_in;
            default: byp_d    = 1'b0;
          endcase
        end
        S_SH_DR: begin
          case (dr_sel)
            DR_IDC:  idc_sh_d = {tdi_s, idc_sh_q[31:1]};
            DR_USR: begin
              usr_sh_d         = usr_sh_q >> 1;
              usr_sh_d[DR_W-1] = tdi_s;
            end
            default: byp_d = tdi_s;
          endcase
        end
        S_UPD_DR: begin
          if (dr_sel == DR_USR) begin
            dr_out_d = usr_sh_q;
            dr_upd_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (state_d == S_TLR) ir_d = INS_IDC;
    end else if (tck_fall) begin
      case (state_q)
        S_SH_IR: begin
          tdo_d    = ir_sh_q[0];
          tdo_oe_d = 1'b1;
        end
        S_SH_DR: begin
          case (dr_sel)
            DR_IDC:  tdo_d = idc_sh_q[0];
            DR_USR:  tdo_d = usr_sh_q[0];
            default: tdo_d = byp_q;
          endcase
          tdo_oe_d = 1'b1;
        end
        default: begin
          tdo_d    = 1'b0;
          tdo_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State register with asynchronous reset. TRST is handled in the
  // next-state logic above because it is a synchronized input.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      trst_sync_q <= '0;
      state_q     <= S_TLR;
      ir_q        <= INS_IDC;
      ir_sh_q     <= '0;
      idc_sh_q    <= '0;
      usr_sh_q    <= '0;
      byp_q       <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      dr_out_q    <= '0;
      dr_upd_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so each flop samples the values
      // from before this edge regardless of statement order.
      tck_sync_q  <= tck_sync_d;
      tms_sync_q  <= tms_sync_d;
      tdi_sync_q  <= tdi_sync_d;
      trst_sync_q <= trst_sync_d;
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sh_q     <= ir_sh_d;
      idc_sh_q    <= idc_sh_d;
      usr_sh_q    <= usr_sh_d;
      byp_q       <= byp_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
      dr_out_q    <= dr_out_d;
      dr_upd_q    <= dr_upd_d;
    end
  end

  assign jtag_tdo    = tdo_q;
  assign jtag_tdo_oe = tdo_oe_q;
  assign user_dr_out = dr_out_q;
  assign user_dr_upd = dr_upd_q;
  assign tap_state   = state_q;
  assign ir_out      = ir_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder. TCK is driven slowly with six or
// more clk per phase. TDO is sampled just before each TCK rise, which is
// how a host samples it.
module tb_jtag_tap_responder;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_trst_n;
  logic        jtag_tdo;
  logic        jtag_tdo_oe;
  logic [31:0] user_dr_in;
  logic [31:0] user_dr_out;
  logic        user_dr_upd;
  logic [3:0]  tap_state;
  logic [4:0]  ir_out;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  jtag_tap_responder dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .jtag_tck    (jtag_tck),
    .jtag_tms    (jtag_tms),
    .jtag_tdi    (jtag_tdi),
    .jtag_trst_n (jtag_trst_n),
    .jtag_tdo    (jtag_tdo),
    .jtag_tdo_oe (jtag_tdo_oe),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_dr_upd (user_dr_upd),
    .tap_state   (tap_state),
    .ir_out      (ir_out)
  );

  always #5 clk = ~clk;

  // Count USER update pulses.
  always @(posedge clk) if (user_dr_upd) upd_cnt <= upd_cnt + 1;

  // Reference 1149.1 transition table.
  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic tms);
    case (s)
      4'hF: ref_next = tms ? 4'hF : 4'hC;
      4'hC: ref_next = tms ? 4'h7 : 4'hC;
      4'h7: ref_next = tms ? 4'h4 : 4'h6;
      4'h6: ref_next = tms ? 4'h1 : 4'h2;
      4'h2: ref_next = tms ? 4'h1 : 4'h2;
      4'h1: ref_next = tms ? 4'h5 : 4'h3;
      4'h3: ref_next = tms ? 4'h0 : 4'h3;
      4'h0: ref_next = tms ? 4'h5 : 4'h2;
      4'h5: ref_next = tms ? 4'h7 : 4'hC;
      4'h4: ref_next = tms ? 4'hF : 4'hE;
      4'hE: ref_next = tms ? 4'h9 : 4'hA;
      4'hA: ref_next = tms ? 4'h9 : 4'hA;
      4'h9: ref_next = tms ? 4'hD : 4'hB;
      4'hB: ref_next = tms ? 4'h8 : 4'hB;
      4'h8: ref_next = tms ? 4'hD : 4'hA;
      default: ref_next = tms ? 4'h7 : 4'hC;
    endcase
  endfunction

  // One TCK period. Returns the TDO and OE values seen just before the rise.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
    @(negedge clk);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (2) @(negedge clk);
    tdo = jtag_tdo;
    oe  = jtag_tdo_oe;
    jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int len);
    logic t, o;
    for (int i = 0; i < len; i++) tck_cycle(bits[i], 1'b0, t, o);
  endtask

  // From RTI: load IR, return to RTI. Captured TDO bits and OE during
  // the whole shift are returned.
  task automatic load_ir(input logic [4:0] val, output logic [4:0] tdo_bits, output logic oe_all);
    logic t, o;
    tms_seq(8'b0011, 4);  // SelDR, SelIR, CapIR, ShIR
    oe_all = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, val[i], t, o);
      tdo_bits[i] = t;
      oe_all = oe_all & o;
    end
    tms_seq(8'b01, 2);    // UpdIR, RTI
  endtask

  // From RTI: shift n DR bits, pass Update-DR, return to RTI.
  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic t, o;
    dout = '0;
    tms_seq(8'b001, 3);   // SelDR, CapDR, ShDR
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t, o);
      dout[i] = t;
    end
    tms_seq(8'b01, 2);    // UpdDR, RTI
  endtask

  task automatic test_reset;
    rst_a = 1'b1; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; jtag_trst_n = 1'b1;
    user_dr_in = 32'h0;
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    if (tap_state !== 4'hF) begin $display("FAIL reset_state got %h exp F", tap_state); n_bad++; end
    n_cmp++;
    if (ir_out !== 5'h01) begin $display("FAIL reset_ir got %h exp 01", ir_out); n_bad++; end
    n_cmp++;
    if ({jtag_tdo, jtag_tdo_oe, user_dr_upd} !== 3'b000) begin
      $display("FAIL reset_outs got tdo/oe/upd %b exp 000", {jtag_tdo, jtag_tdo_oe, user_dr_upd}); n_bad++;
    end
    n_cmp++;
    if (user_dr_out !== 32'h0) begin $display("FAIL reset_dr_out got %h exp 0", user_dr_out); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_idcode;
    logic [63:0] d;
    int c0;
    tms_seq(8'b0001_1111, 6);
    if (tap_state !== 4'hC) begin $display("FAIL idc_rti got %h exp C", tap_state); n_bad++; end
    n_cmp++;
    c0 = upd_cnt;
    scan_dr(64'h0, 32, d);
    if (d[31:0] !== 32'h0000_0001) begin $display("FAIL idc_tdo got %h exp 00000001", d[31:0]); n_bad++; end
    n_cmp++;
    if (ir_out !== 5'h01) begin $display("FAIL idc_ir got %h exp 01", ir_out); n_bad++; end
    n_cmp++;
    if (upd_cnt - c0 !== 0) begin $display("FAIL idc_no_upd got %0d exp 0", upd_cnt - c0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_bypass;
    logic [4:0]  ib;
    logic        oe;
    logic [63:0] d;
    load_ir(5'h1F, ib, oe);
    if (ir_out !== 5'h1F) begin $display("FAIL byp_ir got %h exp 1F", ir_out); n_bad++; end
    n_cmp++;
    scan_dr(64'b1101, 4, d);
    if (d[3:0] !== 4'b1010) begin $display("FAIL byp_tdo got %b exp 1010", d[3:0]); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_user;
    logic [4:0]  ib;
    logic        oe;
    logic [63:0] d;
    int c0;
    user_dr_in = 32'hA5A5_0F0F;
    load_ir(5'h02, ib, oe);
    if (ir_out !== 5'h02) begin $display("FAIL usr_ir got %h exp 02", ir_out); n_bad++; end
    n_cmp++;
    c0 = upd_cnt;
    scan_dr(64'hDEAD_BEEF, 32, d);
    repeat (2) @(negedge clk);
    if (d[31:0] !== 32'hA5A5_0F0F) begin $display("FAIL usr_tdo got %h exp A5A50F0F", d[31:0]); n_bad++; end
    n_cmp++;
    if (user_dr_out !== 32'hDEAD_BEEF) begin $display("FAIL usr_out got %h exp DEADBEEF", user_dr_out); n_bad++; end
    n_cmp++;
    if (upd_cnt - c0 !== 1) begin $display("FAIL usr_upd_cnt got %0d exp 1", upd_cnt - c0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_ir_capture;
    logic [4:0] ib;
    logic       oe;
    if (jtag_tdo_oe !== 1'b0) begin $display("FAIL ir_oe_before got %b exp 0", jtag_tdo_oe); n_bad++; end
    n_cmp++;
    load_ir(5'h02, ib, oe);
    if (ib[1:0] !== 2'b01) begin $display("FAIL ir_capture got %b exp 01", ib[1:0]); n_bad++; end
    n_cmp++;
    if (ib !== 5'b00001) begin $display("FAIL ir_capture_all got %b exp 00001", ib); n_bad++; end
    n_cmp++;
    if (oe !== 1'b1) begin $display("FAIL ir_oe_shift got %b exp 1", oe); n_bad++; end
    n_cmp++;
    if (jtag_tdo_oe !== 1'b0) begin $display("FAIL ir_oe_after got %b exp 0", jtag_tdo_oe); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_trst;
    tms_seq(8'b00001, 5);  // SelDR, CapDR, ShDR, shift, shift
    if ({tap_state, jtag_tdo_oe} !== {4'h2, 1'b1}) begin
      $display("FAIL trst_pre got state %h oe %b exp 2 1", tap_state, jtag_tdo_oe); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    jtag_trst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (tap_state !== 4'hF) begin $display("FAIL trst_state got %h exp F", tap_state); n_bad++; end
    n_cmp++;
    if (ir_out !== 5'h01) begin $display("FAIL trst_ir got %h exp 01", ir_out); n_bad++; end
    n_cmp++;
    if (user_dr_out !== 32'hDEAD_BEEF) begin $display("FAIL trst_dr_out got %h exp DEADBEEF", user_dr_out); n_bad++; end
    n_cmp++;
    if (jtag_tdo_oe !== 1'b0) begin $display("FAIL trst_oe got %b exp 0", jtag_tdo_oe); n_bad++; end
    n_cmp++;
    jtag_trst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overrun;
    logic [63:0] d;
    tms_seq(8'b0, 1);      // TLR -> RTI
    scan_dr(64'b01, 34, d);
    if (d[33:0] !== 34'h1_0000_0001) begin $display("FAIL overrun_tdo got %h exp 100000001", d[33:0]); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_all_states;
    logic [7:0] bits;
    int         len;
    logic [3:0] exp_s;
    tms_seq(8'h1F, 5);
    for (int k = 0; k < 16; k++) begin
      case (k)
        0:  begin bits = 8'b0;       len = 1; exp_s = 4'hC; end
        1:  begin bits = 8'b10;      len = 2; exp_s = 4'h7; end
        2:  begin bits = 8'b010;     len = 3; exp_s = 4'h6; end
        3:  begin bits = 8'b0010;    len = 4; exp_s = 4'h2; end
        4:  begin bits = 8'b1010;    len = 4; exp_s = 4'h1; end
        5:  begin bits = 8'b01010;   len = 5; exp_s = 4'h3; end
        6:  begin bits = 8'b101010;  len = 6; exp_s = 4'h0; end
        7:  begin bits = 8'b11010;   len = 5; exp_s = 4'h5; end
        8:  begin bits = 8'b110;     len = 3; exp_s = 4'h4; end
        9:  begin bits = 8'b0110;    len = 4; exp_s = 4'hE; end
        10: begin bits = 8'b00110;   len = 5; exp_s = 4'hA; end
        11: begin bits = 8'b10110;   len = 5; exp_s = 4'h9; end
        12: begin bits = 8'b010110;  len = 6; exp_s = 4'hB; end
        13: begin bits = 8'b1010110; len = 7; exp_s = 4'h8; end
        14: begin bits = 8'b110110;  len = 6; exp_s = 4'hD; end
        default: begin bits = 8'b0;  len = 0; exp_s = 4'hF; end
      endcase
      tms_seq(bits, len);
      if (tap_state !== exp_s) begin $display("FAIL walk_to_%0d got %h exp %h", k, tap_state, exp_s); n_bad++; end
      n_cmp++;
      tms_seq(8'h1F, 5);
      if (tap_state !== 4'hF) begin $display("FAIL tms5_from_%h got %h exp F", exp_s, tap_state); n_bad++; end
      n_cmp++;
    end
  endtask

  task automatic test_random_walk;
    logic [3:0] exp_s = 4'hF;
    logic       tms, t, o;
    for (int i = 0; i < 60; i++) begin
      tms = 1'($urandom_range(0, 1));
      exp_s = ref_next(exp_s, tms);
      tck_cycle(tms, 1'($urandom_range(0, 1)), t, o);
      if (tap_state !== exp_s) begin $display("FAIL rand_step_%0d got %h exp %h", i, tap_state, exp_s); n_bad++; end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_bypass;
    test_user;
    test_ir_capture;
    test_trst;
    test_overrun;
    test_all_states;
    test_random_walk;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
